// File: rtl/stream_inst_dispatch.sv
// stream_inst_dispatch
//
// Clocked consumer behind the five-way stream-instruction mutex merge. Each
// rising edge of the merged drive captures the source index and instruction
// word into a small FIFO. The FIFO head is issued to the datapath over
// valid/ready, and a one-cycle free pulse returns credit to the merge.
//
// Optional feature (build macro STREAM_DISPATCH_CNT_EN): five saturating
// per-source issue counters exported on o_cnt.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_drive         merged drive (asynchronous), synchronized internally
//   i_src, i_inst   source index and instruction word for the active drive
//   o_free          one-cycle credit pulse back to the merge
//   o_valid, o_src, o_inst, i_ready   issue handshake (head of FIFO)
//   o_full, o_empty FIFO status
//   o_err           sticky: overflow, illegal source, or owed-free violation
//   o_cnt           per-source issue counts (STREAM_DISPATCH_CNT_EN only)

module stream_inst_dispatch #(
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [2:0]        i_src,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_free,
    output logic              o_valid,
    output logic [2:0]        o_src,
    output logic [INST_W-1:0] o_inst,
    input  logic              i_ready,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err
`ifdef STREAM_DISPATCH_CNT_EN
    ,
    output logic [5*CNT_W-1:0] o_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("stream_inst_dispatch: DEPTH must be a power of two >= 2, CNT_W >= 1");
    end

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e            state;
    logic [2:0]        sync_q;          // [0],[1] synchronizer, [2] edge-detect history
    logic [AW:0]       wptr, rptr;
    logic              free_q, free_pend, err_q;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [2:0]        src_mem  [DEPTH];

    logic        strobe, pop, ptr_full, accept, will_fill, free_nxt;
    logic        drop, illegal, violation;
    logic [AW:0] count;

    assign strobe   = sync_q[1] & ~sync_q[2];
    assign pop      = o_valid & i_ready;
    assign count    = wptr - rptr;
    assign ptr_full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop in the same cycle frees a slot, so a capture at full is still accepted.
    assign accept    = strobe & (~ptr_full | pop);
    // Capture without pop that makes the FIFO full: the free is owed, not issued.
    assign will_fill = accept & ~pop & (count == (AW + 1)'(DEPTH - 1));
    assign free_nxt  = (accept & ~will_fill) | (pop & free_pend);

    assign drop      = strobe & ptr_full & ~pop;
    assign illegal   = strobe & (i_src > 3'd4);
    assign violation = strobe & free_pend & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            state     <= StEmpty;
            free_q    <= 1'b0;
            free_pend <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], i_drive};
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;

            case (state)
                StEmpty:   if (accept) state <= StPartial;
                StPartial: begin
                    if (accept && !pop) begin
                        state <= (count == (AW + 1)'(DEPTH - 1)) ? StFull : StPartial;
                    end else if (pop && !accept) begin
                        state <= (count == (AW + 1)'(1)) ? StEmpty : StPartial;
                    end
                end
                StFull:    if (pop && !accept) state <= StPartial;
                default:   state <= StEmpty;
            endcase

            free_q <= free_nxt;
            if (will_fill)  free_pend <= 1'b1;
            else if (pop)   free_pend <= 1'b0;
            if (drop || illegal || violation) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while o_valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            inst_mem[wptr[AW-1:0]] <= i_inst;
            src_mem[wptr[AW-1:0]]  <= i_src;
        end
    end

    assign o_free  = free_q;
    assign o_err   = err_q;
    assign o_empty = (state == StEmpty);
    assign o_full  = (state == StFull);
    assign o_valid = ~o_empty;
    assign o_src   = src_mem[rptr[AW-1:0]];
    assign o_inst  = inst_mem[rptr[AW-1:0]];

`ifdef STREAM_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
        end else if (pop && o_src <= 3'd4) begin
            for (int k = 0; k < 5; k++) begin
                if (o_src == 3'(k) && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 5; k++) begin : g_cnt_out
        assign o_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule
